// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the immediate encoder.
// Holds the FSM state enumeration, the rotation field width, the imm8
// field width and the last rotation value tried before giving up.
package imm_encoder_pkg;

   localparam int ROT_W   = 4;
   localparam int IMM8_W  = 8;
   localparam int IMM12_W = ROT_W + IMM8_W;

   // Last rotation index tried before the value is declared non-encodable.
   localparam logic [ROT_W-1:0] ROT_MAX = 4'd15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/imm_encoder_rol32.sv
// 32-bit rotate-left by a variable amount (purely combinational).
// Ports:
//   data   [31:0] in  : word to rotate
//   amount [4:0]  in  : rotate-left distance in bits
//   result [31:0] out : data rotated left by amount, no bits lost
module rol32 (
   input  logic [31:0] data,
   input  logic [4:0]  amount,
   output logic [31:0] result
);

   logic [63:0] doubled;

   // Shifting a doubled copy left keeps the wrapped bits in the upper half.
   assign doubled = {data, data} << amount;
   assign result  = doubled[63:32];

endmodule

// File: rtl/imm_encoder.sv
// Iterative encoder for ARM-style data-processing immediates.
// A constant is encodable when some even left-rotation of it fits in 8 bits;
// the search tries one rotation per cycle, lowest first, so the smallest
// matching rotation wins.
// Ports:
//   clk          in  : clock, rising edge
//   reset        in  : synchronous active-high reset
//   start        in  : encode request, taken only in IDLE
//   value [31:0] in  : constant to encode, captured on the accepting edge
//   busy         out : high while searching
//   done         out : one-cycle completion pulse
//   valid        out : result is encodable
//   imm12 [11:0] out : {rot, imm8}; imm8 rotated right by 2*rot gives value
//   fsm_state[1:0] out : current FSM state (debug visibility)
// Handshake: start is a request with no ready; it is accepted only on an edge
// where the FSM is in IDLE and ignored otherwise. done pulses once per accepted
// request; imm12/valid stay stable from that pulse until the next accepted start.
module imm_encoder
   import imm_encoder_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [31:0]         value,
   output logic                busy,
   output logic                done,
   output logic                valid,
   output logic [IMM12_W-1:0]  imm12,
   output logic [1:0]          fsm_state
);

   state_t             state;
   logic [31:0]        value_q;
   logic [ROT_W-1:0]   rot;
   logic [31:0]        cand;

   // Candidate for the current rotation index; rotate distance is 2*rot.
   rol32 u_rol32 (
      .data   (value_q),
      .amount ({rot, 1'b0}),
      .result (cand)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         value_q <= '0;
         rot     <= '0;
         done    <= 1'b0;
         valid   <= 1'b0;
         imm12   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  value_q <= value;
                  rot     <= '0;
                  valid   <= 1'b0;
                  imm12   <= '0;
                  state   <= SEARCH;
               end
            end
            SEARCH: begin
               if (cand[31:IMM8_W] == '0) begin
                  imm12 <= {rot, cand[IMM8_W-1:0]};
                  valid <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (rot == ROT_MAX) begin
                  imm12 <= '0;
                  valid <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  rot <= rot + ROT_W'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state == SEARCH);
   assign fsm_state = state;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vectors with hand-computed results, a
// sequence/reset scenario and a batch of random values checked against a
// small reference encoder. Expected results go into a queue; a monitor pops
// and compares whenever done is seen.
module tb_imm_encoder;

   localparam int W = 77; // {done_edge[31:0], value[31:0], valid, imm12[11:0]}

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] value;
   logic        busy;
   logic        done;
   logic        valid;
   logic [11:0] imm12;
   logic [1:0]  fsm_state;

   int checks;
   int failures;
   int cyc;

   logic [W-1:0] exp_q[$];

   logic        last_valid;
   logic [11:0] last_imm12;

   imm_encoder dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .value     (value),
      .busy      (busy),
      .done      (done),
      .valid     (valid),
      .imm12     (imm12),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cyc equals the index of the most recent rising edge.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] rol(input logic [31:0] v, input int s);
      if (s == 0) return v;
      return (v << s) | (v >> (32 - s));
   endfunction

   function automatic logic [31:0] ror(input logic [31:0] v, input int s);
      if (s == 0) return v;
      return (v >> s) | (v << (32 - s));
   endfunction

   // Reference: {found, rot, imm8}, lowest matching rotation.
   function automatic logic [12:0] ref_enc(input logic [31:0] v);
      logic [31:0] c;
      for (int r = 0; r < 16; r++) begin
         c = rol(v, 2 * r);
         if (c[31:8] == 24'd0) return {1'b1, 4'(r), c[7:0]};
      end
      return 13'd0;
   endfunction

   // ---------------- driver tasks (positioned just after a falling edge) ----------------
   // Issue one request; offset is the number of edges after acceptance at
   // which DONE is expected to be entered.
   task automatic issue(input logic [31:0] v, input logic exp_valid,
                        input logic [11:0] exp_imm, input int offset);
      int n;
      n = cyc + 1;
      exp_q.push_back({32'(n + offset), v, exp_valid, exp_imm});
      last_valid = exp_valid;
      last_imm12 = exp_imm;
      start = 1'b1;
      value = v;
      @(negedge clk);
      start = 1'b0;
      value = $urandom;
   endtask

   // Wait (bounded) for done, then move to the first IDLE cycle and check
   // that the result is still held.
   task automatic wait_done();
      int t;
      t = 0;
      while (!done && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("done_timeout", 32'(t < 40), 32'd1);
      @(negedge clk);
      chk("hold_valid", 32'(valid), 32'(last_valid));
      chk("hold_imm12", 32'(imm12), 32'(last_imm12));
      chk("idle_state", 32'(fsm_state), 32'd0);
   endtask

   task automatic run(input logic [31:0] v, input logic exp_valid,
                      input logic [11:0] exp_imm, input int offset);
      issue(v, exp_valid, exp_imm, offset);
      wait_done();
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [31:0]  ev;
      logic         ok;
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e  = exp_q.pop_front();
            ev = e[44:13];
            chk("done_edge", 32'(cyc), e[76:45]);
            chk("valid", 32'(valid), 32'(e[12]));
            chk("imm12", 32'(imm12), 32'(e[11:0]));
            chk("busy_at_done", 32'(busy), 32'd0);
            if (valid) begin
               chk("decode", ror({24'd0, imm12[7:0]}, 2 * int'(imm12[11:8])), ev);
            end else begin
               ok = 1'b1;
               for (int r = 0; r < 16; r++) begin
                  if (rol(ev, 2 * r) < 32'h100) ok = 1'b0;
               end
               chk("not_encodable", 32'(ok), 32'd1);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int          n;
      logic [12:0] r;
      logic [31:0] v;
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      start    = 1'b0;
      value    = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_valid", 32'(valid),     32'd0);
      chk("rst_imm12", 32'(imm12),     32'd0);
      chk("rst_state", 32'(fsm_state), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Directed vectors with hand-computed results.
      run(32'h0000_00FF, 1'b1, 12'h0FF, 1);
      run(32'hC000_003F, 1'b1, 12'h1FF, 2);
      run(32'hFF00_0000, 1'b1, 12'h4FF, 5);
      run(32'h0000_0102, 1'b0, 12'h000, 16);
      run(32'h0000_0000, 1'b1, 12'h000, 1);
      run(32'hF000_000F, 1'b1, 12'h2FF, 3);
      run(32'h0000_03FC, 1'b1, 12'hFFF, 16);  // match only at the last rotation
      run(32'h0000_0100, 1'b1, 12'hC01, 13);  // lowest of several matches

      // Busy while searching.
      issue(32'hFF00_0000, 1'b1, 12'h4FF, 5);
      chk("busy_search", 32'(busy), 32'd1);
      // Second start two edges after the first must be ignored.
      @(negedge clk);
      start = 1'b1;
      value = 32'h0000_00FF;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset in the middle of a non-encodable search.
      start = 1'b1;
      value = 32'h0000_0102;
      n = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < n + 6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_state", 32'(fsm_state), 32'd0);
      chk("abort_busy",  32'(busy),      32'd0);
      chk("abort_done",  32'(done),      32'd0);
      chk("abort_valid", 32'(valid),     32'd0);
      chk("abort_imm12", 32'(imm12),     32'd0);
      reset = 1'b0;
      // New request right after the aborted one; DONE expected one edge later.
      last_valid = 1'b1;
      last_imm12 = 12'h0FF;
      run(32'h0000_00FF, 1'b1, 12'h0FF, 1);

      // Random values: half built to be encodable, half arbitrary.
      for (int i = 0; i < 1000; i++) begin
         if (i % 2 == 0) v = ror({24'd0, 8'($urandom)}, 2 * $urandom_range(0, 15));
         else            v = $urandom;
         r = ref_enc(v);
         run(v, r[12], r[11:0], r[12] ? int'(r[11:8]) + 1 : 16);
      end

      repeat (2) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
